// File: rtl/down_counter_pkg.sv
// Shared state encodings for the lab counters (down_counter and its up-counter companion).
package down_counter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/down_counter_ctrl.sv
// Three-state control FSM for down_counter: registered busy/done, plus decrement and reload selects.
// Build option: DOWN_COUNTER_AUTORELOAD_EN keeps the FSM in RUN and reloads at zero instead of stopping.
module down_counter_ctrl
  import down_counter_pkg::*;
(
  input  logic   clk,
  input  logic   reset,
  input  logic   load,
  input  logic   start,
  input  logic   pause,
  input  logic   cnt_zero,
  input  logic   cnt_one,
  input  logic   reload_zero,
  output state_t state,
  output logic   busy,
  output logic   done,
  output logic   dec_en,
  output logic   reload_sel
);

  assign dec_en = (state == RUN) && !pause && !cnt_zero;

`ifdef DOWN_COUNTER_AUTORELOAD_EN
  // The edge after reaching zero wraps back to the loaded value while still running.
  assign reload_sel = ((state == DONE) && start && !reload_zero) ||
                      ((state == RUN) && !pause && cnt_zero);
`else
  assign reload_sel = (state == DONE) && start && !reload_zero;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (load) begin
        state <= IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start && !cnt_zero) begin
              state <= RUN;
              busy  <= 1'b1;
            end
          end
          RUN: begin
            if (!pause && cnt_one) begin
              done <= 1'b1;
`ifndef DOWN_COUNTER_AUTORELOAD_EN
              state <= DONE;
              busy  <= 1'b0;
`endif
            end
          end
          DONE: begin
            if (start && !reload_zero) begin
              state <= RUN;
              busy  <= 1'b1;
            end
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/down_counter.sv
// Loadable down-counter/timer with one-cycle done strobe; count and reload register live here.
// Build option: DOWN_COUNTER_AUTORELOAD_EN makes the count wrap to the loaded value and run continuously.
module down_counter
  import down_counter_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             start,
  input  logic             pause,
  output logic [WIDTH-1:0] counter_down,
  output logic             busy,
  output logic             done
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] reload_q;
  logic             dec_en;
  logic             reload_sel;
  state_t           state;

  down_counter_ctrl u_ctrl (
    .clk         (clk),
    .reset       (reset),
    .load        (load),
    .start       (start),
    .pause       (pause),
    .cnt_zero    (counter_down == '0),
    .cnt_one     (counter_down == ONE),
    .reload_zero (reload_q == '0),
    .state       (state),
    .busy        (busy),
    .done        (done),
    .dec_en      (dec_en),
    .reload_sel  (reload_sel)
  );

  // Load outranks everything; dec_en is never set at zero, so the count cannot wrap.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      counter_down <= '0;
      reload_q     <= '0;
    end else if (load) begin
      counter_down <= load_val;
      reload_q     <= load_val;
    end else if (reload_sel) begin
      counter_down <= reload_q;
    end else if (dec_en) begin
      counter_down <= counter_down - ONE;
    end
  end

endmodule

// File: tb/tb_down_counter.sv
// Directed self-checking bench for down_counter; expected values are hand-computed per step.
module tb_down_counter;
  import down_counter_pkg::*;

  localparam int WIDTH = 4;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             load = 1'b0;
  logic [WIDTH-1:0] load_val = '0;
  logic             start = 1'b0;
  logic             pause = 1'b0;
  logic [WIDTH-1:0] counter_down;
  logic             busy;
  logic             done;

  int checks = 0;
  int passed = 0;

  down_counter #(.WIDTH(WIDTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .load         (load),
    .load_val     (load_val),
    .start        (start),
    .pause        (pause),
    .counter_down (counter_down),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic expect_out(input string tag, input int c, input bit b, input bit d);
    chk({tag, ".count"}, 32'(counter_down), 32'(c));
    chk({tag, ".busy"},  32'(busy), 32'(b));
    chk({tag, ".done"},  32'(done), 32'(d));
  endtask

  task automatic do_load(input int v);
    load = 1'b1;
    load_val = WIDTH'(v);
    tick();
    load = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    // Reset state
    tick();
    expect_out("reset", 0, 0, 0);
    chk("reset.state", 32'(dut.u_ctrl.state), 32'(IDLE));
    reset = 1'b1;
    tick();
    expect_out("post_reset", 0, 0, 0);

`ifdef DOWN_COUNTER_AUTORELOAD_EN
    do_load(3);
    expect_out("ar.load", 3, 0, 0);
    do_start();
    expect_out("ar.start", 3, 1, 0);
    for (int k = 0; k < 12; k++) begin
      tick();
      expect_out($sformatf("ar.cyc%0d", k), 3 - ((k + 1) % 4), 1, ((k + 1) % 4) == 3);
    end
    do_load(2);
    expect_out("ar.reload_abort", 2, 0, 0);
`else
    // Basic count from 5
    do_load(5);
    expect_out("basic.load", 5, 0, 0);
    do_start();
    expect_out("basic.start", 5, 1, 0);
    tick(); expect_out("basic.4", 4, 1, 0);
    tick(); expect_out("basic.3", 3, 1, 0);
    tick(); expect_out("basic.2", 2, 1, 0);
    tick(); expect_out("basic.1", 1, 1, 0);
    tick(); expect_out("basic.0", 0, 0, 1);
    tick(); expect_out("basic.hold", 0, 0, 0);

    // Pause for 3 cycles at count 2
    do_load(4);
    expect_out("pause.load", 4, 0, 0);
    do_start();
    expect_out("pause.start", 4, 1, 0);
    tick(); expect_out("pause.3", 3, 1, 0);
    tick(); expect_out("pause.2", 2, 1, 0);
    pause = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      expect_out($sformatf("pause.hold%0d", k), 2, 1, 0);
    end
    pause = 1'b0;
    tick(); expect_out("pause.1", 1, 1, 0);
    tick(); expect_out("pause.0", 0, 0, 1);

    // Load abort at count 5, then run the new value
    do_load(7);
    do_start();
    expect_out("abort.start", 7, 1, 0);
    tick(); expect_out("abort.6", 6, 1, 0);
    tick(); expect_out("abort.5", 5, 1, 0);
    do_load(3);
    expect_out("abort.load", 3, 0, 0);
    tick(); expect_out("abort.idle", 3, 0, 0);
    do_start();
    expect_out("abort.restart", 3, 1, 0);
    tick(); expect_out("abort.2", 2, 1, 0);
    tick(); expect_out("abort.1", 1, 1, 0);
    tick(); expect_out("abort.0", 0, 0, 1);

    // Retrigger from DONE
    do_load(2);
    do_start();
    expect_out("retrig.start", 2, 1, 0);
    tick(); expect_out("retrig.1", 1, 1, 0);
    tick(); expect_out("retrig.0", 0, 0, 1);
    tick(); expect_out("retrig.hold", 0, 0, 0);
    chk("retrig.state_done", 32'(dut.u_ctrl.state), 32'(DONE));
    do_start();
    expect_out("retrig.reload", 2, 1, 0);
    tick(); expect_out("retrig.again1", 1, 1, 0);
    tick(); expect_out("retrig.again0", 0, 0, 1);

    // Start with zero loaded is ignored
    do_load(0);
    do_start();
    expect_out("zero.start", 0, 0, 0);
    chk("zero.state", 32'(dut.u_ctrl.state), 32'(IDLE));
    tick(); expect_out("zero.hold", 0, 0, 0);
`endif

    // Asynchronous reset mid-count from 9
    do_load(9);
    do_start();
    tick();
    expect_out("areset.8", 8, 1, 0);
    #2 reset = 1'b0;
    #1;
    expect_out("areset.async", 0, 0, 0);
    chk("areset.state", 32'(dut.u_ctrl.state), 32'(IDLE));
    reset = 1'b1;
    tick();
    expect_out("areset.after", 0, 0, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
